// File: rtl/sdram_arbiter.sv
// Two-port SDRAM access arbiter with periodic auto-refresh and fixed-length access slots.
// Define SDRAM_ARB_RR_EN for round-robin port arbitration (default: port 1 over port 0).
module sdram_arbiter #(
  parameter int SLOT           = 12,
  parameter int REFRESH_PERIOD = 390,
  parameter int AW             = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] a0,
  input  logic [15:0]   d0,
  output logic [15:0]   q0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [15:0]   d1,
  output logic [15:0]   q1,
  output logic          ack1,
  input  logic          memReady,
  output logic          memRd,
  output logic          memWr,
  output logic          memRf,
  output logic [AW-1:0] memA,
  output logic [15:0]   memD,
  input  logic [15:0]   memQ
);

  localparam int CW = $clog2(SLOT);
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 2);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_RD, K_WR, K_RF} kind_t;

  state_t        state;
  kind_t         kind;
  logic          owner;
  logic [CW-1:0] slot_cnt;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;

  logic          pick1;
  logic          sel_we;
  logic [AW-1:0] sel_a;
  logic [15:0]   sel_d;

`ifdef SDRAM_ARB_RR_EN
  logic last1;

  always_comb begin
    pick1 = req1 && (!req0 || !last1);
  end
`else
  always_comb begin
    pick1 = req1;
  end
`endif

  assign sel_we = pick1 ? we1 : we0;
  assign sel_a  = pick1 ? a1  : a0;
  assign sel_d  = pick1 ? d1  : d0;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values; the async reset puts strobes high without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      kind     <= K_RD;
      owner    <= 1'b0;
      slot_cnt <= '0;
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      memRd    <= 1'b1;
      memWr    <= 1'b1;
      memRf    <= 1'b1;
      memA     <= '0;
      memD     <= '0;
      q0       <= '0;
      q1       <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last1    <= 1'b1;
`endif
    end else begin
      // Strobes and acks are single-cycle pulses: default them inactive.
      memRd <= 1'b1;
      memWr <= 1'b1;
      memRf <= 1'b1;
      ack0  <= 1'b0;
      ack1  <= 1'b0;

      case (state)
        S_INIT: begin
          if (memReady) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!memReady) begin
            state <= S_INIT;
          end else if (ref_pend) begin
            kind     <= K_RF;
            memRf    <= 1'b0;
            ref_pend <= 1'b0;
            state    <= S_STROBE;
          end else if (req0 || req1) begin
            owner <= pick1;
            memA  <= sel_a;
            memD  <= sel_d;
            kind  <= sel_we ? K_WR : K_RD;
            if (sel_we) memWr <= 1'b0;
            else        memRd <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last1 <= pick1;
`endif
            state <= S_STROBE;
          end
        end
        S_STROBE: begin
          slot_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (slot_cnt == SLOT_LAST) begin
            state <= S_DONE;
            if (kind != K_RF) begin
              if (owner) ack1 <= 1'b1;
              else       ack0 <= 1'b1;
            end
            if (kind == K_RD) begin
              if (owner) q1 <= memQ;
              else       q0 <= memQ;
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase

      // Placed after the FSM so a fresh expiry wins over a same-cycle clear.
      if (state != S_INIT) begin
        if (ref_cnt == REF_LAST) begin
          ref_cnt  <= '0;
          ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter: reads, writes, conflicts, refresh,
// async reset and controller loss, with hand-computed cycle positions.
module tb_sdram_arbiter;

  localparam int AW = 24;
  typedef logic [AW-1:0] addr_t;

`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [15:0]   d0 = '0, d1 = '0;
  logic [15:0]   q0, q1;
  logic          ack0, ack1;
  logic          memReady = 1'b0;
  logic          memRd, memWr, memRf;
  logic [AW-1:0] memA;
  logic [15:0]   memD;
  logic [15:0]   memQ = '0;

  sdram_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .a0(a0), .d0(d0), .q0(q0), .ack0(ack0),
    .req1(req1), .we1(we1), .a1(a1), .d1(d1), .q1(q1), .ack1(ack1),
    .memReady(memReady), .memRd(memRd), .memWr(memWr), .memRf(memRf),
    .memA(memA), .memD(memD), .memQ(memQ)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Observation record of one window; indices count negedges from 1.
  int          st_at[$];
  int          st_kind[$];   // 0 read, 1 write, 2 refresh, 3 illegal mix
  addr_t       st_addr[$];
  logic [15:0] st_data[$];
  int          ack0_at[$];
  int          ack1_at[$];
  logic [15:0] q0_ack, q1_ack;
  bit          ad_changed;
  bit          rereq0 = 1'b0;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic addr_t qaddr(input addr_t q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  // Acts as the requesters (drop req on ack unless re-requesting) and logs strobes/acks.
  task automatic observe(input int n);
    addr_t       a_ref = '0;
    logic [15:0] d_ref = '0;
    bit          in_slot = 1'b0;
    st_at.delete(); st_kind.delete(); st_addr.delete(); st_data.delete();
    ack0_at.delete(); ack1_at.delete();
    ad_changed = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (!memRd || !memWr || !memRf) begin
        st_at.push_back(k);
        st_kind.push_back(({memRd, memWr, memRf} == 3'b011) ? 0 :
                          ({memRd, memWr, memRf} == 3'b101) ? 1 :
                          ({memRd, memWr, memRf} == 3'b110) ? 2 : 3);
        st_addr.push_back(memA);
        st_data.push_back(memD);
        a_ref = memA; d_ref = memD; in_slot = 1'b1;
      end else if (in_slot && (memA !== a_ref || memD !== d_ref)) begin
        ad_changed = 1'b1;
      end
      if (ack0 === 1'b1) begin
        ack0_at.push_back(k); q0_ack = q0; in_slot = 1'b0;
        if (!rereq0) req0 = 1'b0;
      end
      if (ack1 === 1'b1) begin
        ack1_at.push_back(k); q1_ack = q1; in_slot = 1'b0;
        req1 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    memReady = 1'b0; rereq0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; memReady = 1'b0;
    @(negedge clock);
    n_tests++;
    if ({memRd, memWr, memRf, ack0, ack1} !== 5'b11100) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 11100", {memRd, memWr, memRf, ack0, ack1});
    end
    n_tests++;
    if (q0 !== 16'h0 || q1 !== 16'h0 || memA !== '0 || memD !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: q0=%h q1=%h memA=%h memD=%h want all 0", q0, q1, memA, memD);
    end
    reset = 1'b0; req0 = 1'b1; a0 = 24'h000777;
    observe(8);
    n_tests++;
    if (st_at.size() != 0) begin
      n_fail++; $display("FAIL init_no_strobe: got %0d strobes want 0", st_at.size());
    end
    req0 = 1'b0;
  endtask

  task automatic test_read();
    do_reset();
    memReady = 1'b1; memQ = 16'hBEEF; a0 = 24'h012345; we0 = 1'b0; req0 = 1'b1;
    observe(30);
    n_tests++;
    if (st_at.size() != 1 || qget(st_at, 0) != 2 || qget(st_kind, 0) != 0) begin
      n_fail++; $display("FAIL read_strobe: count=%0d at=%0d kind=%0d want 1/2/0",
                         st_at.size(), qget(st_at, 0), qget(st_kind, 0));
    end
    n_tests++;
    if (qaddr(st_addr, 0) !== 24'h012345) begin
      n_fail++; $display("FAIL read_addr: got %h want 012345", qaddr(st_addr, 0));
    end
    n_tests++;
    if (ack0_at.size() != 1 || qget(ack0_at, 0) != 14 || ack1_at.size() != 0) begin
      n_fail++; $display("FAIL read_ack: ack0 count=%0d at=%0d ack1 count=%0d want 1/14/0",
                         ack0_at.size(), qget(ack0_at, 0), ack1_at.size());
    end
    n_tests++;
    if (q0_ack !== 16'hBEEF || q0 !== 16'hBEEF) begin
      n_fail++; $display("FAIL read_q0: at ack %h later %h want BEEF", q0_ack, q0);
    end
  endtask

  task automatic test_write();
    do_reset();
    memReady = 1'b1; memQ = 16'h1234; a1 = 24'h000100; d1 = 16'hA55A; we1 = 1'b1; req1 = 1'b1;
    observe(30);
    n_tests++;
    if (st_at.size() != 1 || qget(st_at, 0) != 2 || qget(st_kind, 0) != 1) begin
      n_fail++; $display("FAIL write_strobe: count=%0d at=%0d kind=%0d want 1/2/1",
                         st_at.size(), qget(st_at, 0), qget(st_kind, 0));
    end
    n_tests++;
    if (qaddr(st_addr, 0) !== 24'h000100 || st_data.size() != 1 || st_data[0] !== 16'hA55A || ad_changed) begin
      n_fail++; $display("FAIL write_addr_data: addr=%h changed=%0d want 000100 A55A stable",
                         qaddr(st_addr, 0), ad_changed);
    end
    n_tests++;
    if (ack1_at.size() != 1 || qget(ack1_at, 0) != 14 || ack0_at.size() != 0) begin
      n_fail++; $display("FAIL write_ack: ack1 count=%0d at=%0d ack0 count=%0d want 1/14/0",
                         ack1_at.size(), qget(ack1_at, 0), ack0_at.size());
    end
    n_tests++;
    if (q1 !== 16'h0000) begin
      n_fail++; $display("FAIL write_q1_unchanged: got %h want 0000", q1);
    end
    we1 = 1'b0;
  endtask

  task automatic test_conflict();
    addr_t first_a, second_a;
    do_reset();
    memReady = 1'b1; memQ = 16'h0F0F;
    a0 = 24'h000AAA; a1 = 24'h000BBB; we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    observe(40);
    first_a  = RR ? 24'h000AAA : 24'h000BBB;
    second_a = RR ? 24'h000BBB : 24'h000AAA;
    n_tests++;
    if (st_at.size() != 2 || qget(st_at, 0) != 2 || qget(st_at, 1) != 16) begin
      n_fail++; $display("FAIL conflict_timing: count=%0d at=%0d,%0d want 2 at 2,16",
                         st_at.size(), qget(st_at, 0), qget(st_at, 1));
    end
    n_tests++;
    if (qaddr(st_addr, 0) !== first_a || qaddr(st_addr, 1) !== second_a) begin
      n_fail++; $display("FAIL conflict_order: got %h,%h want %h,%h",
                         qaddr(st_addr, 0), qaddr(st_addr, 1), first_a, second_a);
    end
    n_tests++;
    if (qget(ack0_at, 0) != (RR ? 14 : 28) || qget(ack1_at, 0) != (RR ? 28 : 14)) begin
      n_fail++; $display("FAIL conflict_acks: ack0=%0d ack1=%0d want %0d,%0d",
                         qget(ack0_at, 0), qget(ack1_at, 0), RR ? 14 : 28, RR ? 28 : 14);
    end
  endtask

  task automatic test_refresh_idle();
    do_reset();
    memReady = 1'b1;
    observe(800);
    n_tests++;
    if (st_at.size() != 2 || qget(st_at, 0) != 392 || qget(st_at, 1) != 782 ||
        qget(st_kind, 0) != 2 || qget(st_kind, 1) != 2) begin
      n_fail++; $display("FAIL refresh_idle: count=%0d at=%0d,%0d want 2 refreshes at 392,782",
                         st_at.size(), qget(st_at, 0), qget(st_at, 1));
    end
  endtask

  task automatic test_refresh_busy();
    int rf_at[$];
    int rd_n = 0;
    do_reset();
    memReady = 1'b1; a0 = 24'h000321; we0 = 1'b0; rereq0 = 1'b1; req0 = 1'b1;
    observe(800);
    for (int i = 0; i < st_at.size(); i++) begin
      if (st_kind[i] == 2) rf_at.push_back(st_at[i]);
      else if (st_kind[i] == 0) rd_n++;
    end
    n_tests++;
    if (rf_at.size() != 2 || qget(rf_at, 0) != 394 || qget(rf_at, 1) != 786) begin
      n_fail++; $display("FAIL refresh_busy_rf: count=%0d at=%0d,%0d want 2 at 394,786",
                         rf_at.size(), qget(rf_at, 0), qget(rf_at, 1));
    end
    n_tests++;
    if (rd_n != 56 || ack0_at.size() != 55) begin
      n_fail++; $display("FAIL refresh_busy_rd: reads=%0d acks=%0d want 56,55", rd_n, ack0_at.size());
    end
    rereq0 = 1'b0; req0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    memReady = 1'b1; memQ = 16'hCAFE; a0 = 24'h00ABCD; we0 = 1'b0; req0 = 1'b1;
    observe(2);
    n_tests++;
    if (memRd !== 1'b0) begin
      n_fail++; $display("FAIL mid_strobe_low: memRd=%b want 0", memRd);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({memRd, memWr, memRf, ack0} !== 4'b1110) begin
      n_fail++; $display("FAIL mid_async_reset: got %b want 1110", {memRd, memWr, memRf, ack0});
    end
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    observe(30);
    n_tests++;
    if (st_at.size() != 0 || ack0_at.size() != 0) begin
      n_fail++; $display("FAIL mid_dropped: strobes=%0d acks=%0d want 0,0", st_at.size(), ack0_at.size());
    end
    a0 = 24'h00D00D; req0 = 1'b1;
    observe(20);
    n_tests++;
    if (qget(st_at, 0) != 1 || qaddr(st_addr, 0) !== 24'h00D00D || qget(ack0_at, 0) != 13 || q0_ack !== 16'hCAFE) begin
      n_fail++; $display("FAIL mid_recover: strobe=%0d addr=%h ack=%0d q0=%h want 1 00D00D 13 CAFE",
                         qget(st_at, 0), qaddr(st_addr, 0), qget(ack0_at, 0), q0_ack);
    end
  endtask

  task automatic test_ready_drop();
    do_reset();
    memReady = 1'b1; memQ = 16'h5151;
    a0 = 24'h00C0DE; we0 = 1'b0; req0 = 1'b1;
    a1 = 24'h00F00D; we1 = 1'b0;
    observe(6);
    memReady = 1'b0; req1 = 1'b1;
    observe(30);
    n_tests++;
    if (ack0_at.size() != 1 || qget(ack0_at, 0) != 8 || q0_ack !== 16'h5151) begin
      n_fail++; $display("FAIL drop_slot_completes: acks=%0d at=%0d q0=%h want 1 at 8 5151",
                         ack0_at.size(), qget(ack0_at, 0), q0_ack);
    end
    n_tests++;
    if (st_at.size() != 0 || ack1_at.size() != 0) begin
      n_fail++; $display("FAIL drop_no_strobe: strobes=%0d ack1=%0d want 0,0", st_at.size(), ack1_at.size());
    end
    memReady = 1'b1;
    observe(10);
    n_tests++;
    if (qget(st_at, 0) != 2 || qget(st_kind, 0) != 0 || qaddr(st_addr, 0) !== 24'h00F00D) begin
      n_fail++; $display("FAIL drop_resume: at=%0d kind=%0d addr=%h want 2 0 00F00D",
                         qget(st_at, 0), qget(st_kind, 0), qaddr(st_addr, 0));
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_conflict();
    test_refresh_idle();
    test_refresh_busy();
    test_reset_mid();
    test_ready_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller between two requesters (port 0 = CPU, port 1 = video/DMA).
- Generates periodic auto-refresh.
- Drives the controller's active-low, falling-edge-detected read/write/refresh strobes.
- Holds address/data stable for each fixed-length access slot and returns a one-cycle ack with read data.
- Sits between the machine core and the SDRAM controller.

Parameters:
- SLOT, 12, cycles from strobe assertion to ack; must cover controller edge-detect latency plus its 8-cycle command sequence.
- REFRESH_PERIOD, 390, cycles between refresh requests (7.8 us at 50 MHz).
- AW, 24, address width.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request, held high until ack0
- we0  in  1  port 0 write (1) / read (0), valid with req0
- a0  in  AW  port 0 word address
- d0  in  16  port 0 write data
- q0  out  16  port 0 read data, valid in ack0 cycle
- ack0  out  1  port 0 one-cycle completion
- req1, we1, a1, d1, q1, ack1: same as port 0, for port 1
- memReady  in  1  controller initialised
- memRd  out  1  read strobe, active-low, idle high
- memWr  out  1  write strobe, active-low, idle high
- memRf  out  1  refresh strobe, active-low, idle high
- memA  out  AW  address to controller
- memD  out  16  write data to controller
- memQ  in  16  read data from controller

Behaviour:
- Reset values:
  - memRd/memWr/memRf = 1; ack0/ack1 = 0; q0/q1/memA/memD = 0.
  - State = INIT; refresh counter = 0; refPend = 0.
- Refresh timer:
  - Counts every cycle outside INIT; at REFRESH_PERIOD-1 it wraps to 0 and sets refPend.
  - refPend is a single flag; multiple expiries before service do not accumulate.
  - refPend clears when its REFRESH slot is granted.
- States:
  - INIT: wait for memReady=1, then go to IDLE.
  - IDLE:
    - memReady=0 -> INIT.
    - Otherwise grant in priority order: refPend, then port 1, then port 0 (fixed priority).
    - On grant: latch memA/memD from the winner, record kind (RD/WR/RF) and owner, go to STROBE.
  - STROBE: drive the selected strobe low for exactly one cycle, counter = 0, go to WAIT.
  - WAIT:
    - Counter increments; memA/memD held constant throughout.
    - When counter = SLOT-2, go to DONE. The STROBE cycle plus WAIT cycles total SLOT cycles.
  - DONE:
    - Read: q<owner> <= memQ; ack<owner> = 1 for exactly this cycle.
    - Write: ack only. Refresh: no ack.
    - Next cycle -> IDLE.
- Latency and handshake:
  - Grant in IDLE cycle T; strobe low at T+1; ack at T+SLOT+1. Minimum spacing between strobes is SLOT+2 cycles.
  - A requester deasserts req in the cycle after ack. A req still high in the cycle immediately after ack is treated as a new request.
  - q holds its value until the next read completes for that port.
- Simultaneous events:
  - Refresh expiry in the same cycle as a port grant: the port wins that slot; refresh is taken next IDLE.
  - Both ports requesting: port 1 first, port 0 next slot.
- Lost controller: memReady falling mid-slot does not abort; the slot completes (ack issued), then IDLE -> INIT.
- Reset mid-operation: strobes return high immediately (asynchronous); the in-flight access is dropped with no ack.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined:
  - Port arbitration is round-robin: the port not served last wins on conflict. Initial "last served" after reset = port 1, so port 0 wins the first conflict.
  - Refresh keeps top priority.
- Undefined: fixed priority, port 1 over port 0.

Test Plan:
- Read after init: reset, memReady=1, req0=1 we0=0 a0=24'h012345, memQ=16'hBEEF -> memRd low one cycle with memA=24'h012345; ack0 one cycle at grant+13 with q0=16'hBEEF; memWr/memRf stay high.
- Write: req1=1 we1=1 a1=24'h000100 d1=16'hA55A -> memWr low one cycle; memD=16'hA55A and memA stable through slot; ack1 at grant+13; q1 unchanged.
- Conflict, fixed priority: req0 and req1 rise same cycle -> port 1 served first, port 0 strobe exactly 14 cycles later. With SDRAM_ARB_RR_EN, first conflict after reset serves port 0 first.
- Refresh: idle ports, REFRESH_PERIOD=390 -> memRf low once every 390 cycles. With req0 continuously re-asserted, a pending refresh is served in the next IDLE and is never skipped.
- Async reset mid-read: assert reset during WAIT -> strobes high and ack low in the same cycle; no ack after release; new request served normally.
- memReady drop: deassert memReady during a WAIT slot -> slot acks, arbiter enters INIT, no strobes until memReady=1.
